x_mem_responder: RTL

//   Memory-side responder for the core's valid/accept bus (o_valid/o_rnw/o_addr/o_data
//   out of the core, i_data/i_accept into it). Holds a word-addressed RAM and answers

---
 rtl/x_mem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/x_mem_responder.sv
// x_mem_responder: word-addressed program/data RAM on the core's valid/accept bus.
// Ports: i_clk, i_rst (async, active-high), i_valid/i_rnw/i_addr/i_data request in;
//        o_accept (1-cycle strobe), o_data (read word), o_err (coincident with accept).
module x_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT        = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_rnw,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic        o_accept,
    output logic [31:0] o_data,
    output logic        o_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        go_resp;
    logic [3:0]  cnt_q;
    logic        rnw_q;
    logic [AW-1:0] idx_q;
    logic [31:0] wdata_q;
    logic        ok_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] hold_q;
    logic [31:0] mem [DEPTH_WORDS];

    // Decode of the live bus address; only meaningful while IDLE.
    logic [31:0]   off;
    logic          in_rng;
    logic          mis;
    logic [AW-1:0] idx;

    assign off    = i_addr - BASE_ADDR;
    assign in_rng = (i_addr >= BASE_ADDR) && (off[31:2] < 30'(DEPTH_WORDS));
    assign mis    = (off[1:0] != 2'b00);
    assign idx    = off[AW+1:2];

    // With zero wait states RESP is entered straight from IDLE, so the
    // RAM read must use the live request rather than the captured one.
    logic          idle;
    logic [AW-1:0] rd_idx;
    logic          rd_ok;
    logic          rd_rnw;

    assign idle   = (state_q == S_IDLE);
    assign rd_idx = idle ? idx    : idx_q;
    assign rd_ok  = idle ? in_rng : ok_q;
    assign rd_rnw = idle ? i_rnw  : rnw_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        go_resp  = 1'b0;
        o_accept = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    if (WAIT == 0) begin
                        state_d = S_RESP;
                        go_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    go_resp = 1'b1;
                end
            end
            S_RESP: begin
                state_d  = S_IDLE;
                o_accept = i_valid;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_err  = o_accept & err_q;
    assign o_data = o_accept ? rdata_q : hold_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= 4'd0;
            rnw_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            hold_q  <= 32'd0;
        end else begin
            if (idle && i_valid) begin
                rnw_q   <= i_rnw;
                idx_q   <= idx;
                wdata_q <= i_data;
                ok_q    <= in_rng;
                err_q   <= !in_rng || mis;
                cnt_q   <= 4'(WAIT);
            end else if (state_q == S_WAIT) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (go_resp) begin
                rdata_q <= (rd_rnw && rd_ok) ? mem[rd_idx] : 32'd0;
            end
            if (o_accept) begin
                hold_q <= rdata_q;
            end
        end
    end

    // RAM array is not reset; writes land only on an accepted, in-range store.
    always_ff @(posedge i_clk) begin
        if (o_accept && !rnw_q && ok_q && !i_rst) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
